// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four mux4to1 requesters and the round-robin arbiter.
interface mux4_rr_arbiter_if;
    logic [3:0] req_i;
    logic       done_i;
    logic [3:0] grant_o;
    logic [1:0] select_o;
    logic       busy_o;
    logic       timeout_o;

    modport master (
        output req_i,
        output done_i,
        input  grant_o,
        input  select_o,
        input  busy_o,
        input  timeout_o
    );

    modport slave (
        input  req_i,
        input  done_i,
        output grant_o,
        output select_o,
        output busy_o,
        output timeout_o
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-input datapath mux.
// A grant is held until done, request drop, or the hold limit, then the
// pointer moves past the holder and the next winner is granted without a bubble.
module mux4_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    mux4_rr_arbiter_if.slave   bus
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    sel_q, sel_d;
    logic                busy_q, busy_d;
    logic                timeout_q, timeout_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;

    logic [IDX_W-1:0]    scan_start;
    logic                win_found;
    logic [IDX_W-1:0]    win_idx;
    logic                end_done;
    logic                end_drop;
    logic                end_limit;

    // Scan starts at the pointer when idle, just past the holder when granted.
    always_comb begin
        scan_start = (state_q == IDLE) ? ptr_q : IDX_W'(sel_q + IDX_W'(1));
    end

    // First asserted request at or after scan_start, wrapping mod 4.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(scan_start + IDX_W'(k));
            if (bus.req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Reasons the current grant ends this cycle.
    always_comb begin
        end_done  = bus.done_i;
        end_drop  = ~bus.req_i[sel_q];
        end_limit = (HOLD_MAX != 0) && (cnt_q == HOLD_W'(HOLD_MAX));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANTED;
                    grant_d = N_REQ'(4'b0001 << win_idx);
                    sel_d   = win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = HOLD_W'(1);
                end
            end
            GRANTED: begin
                if (end_done || end_drop || end_limit) begin
                    ptr_d     = IDX_W'(sel_q + IDX_W'(1));
                    timeout_d = end_limit && !end_done && !end_drop;
                    if (win_found) begin
                        grant_d = N_REQ'(4'b0001 << win_idx);
                        sel_d   = win_idx;
                        cnt_d   = HOLD_W'(1);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != {HOLD_W{1'b1}}) begin
                    // Saturate so an unlimited hold never wraps the counter.
                    cnt_d = HOLD_W'(cnt_q + HOLD_W'(1));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    assign bus.grant_o   = grant_q;
    assign bus.select_o  = sel_q;
    assign bus.busy_o    = busy_q;
    assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (hold limit 4 and unlimited) share
// stimulus and are compared against an abstract round-robin model each cycle.
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Model state per instance: index 0 -> HOLD_MAX=4, index 1 -> HOLD_MAX=0.
    int hold_max [2] = '{4, 0};
    int m_holder [2];   // -1 when idle
    int m_cnt    [2];
    int m_ptr    [2];
    int m_sel    [2];
    int m_to     [2];

    always #5 clk = ~clk;

    mux4_rr_arbiter_if bus4 ();
    mux4_rr_arbiter_if bus0 ();

    assign bus4.req_i  = req;
    assign bus4.done_i = done;
    assign bus0.req_i  = req;
    assign bus0.done_i = done;

    mux4_rr_arbiter #(.HOLD_MAX(4), .HOLD_W(8)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    mux4_rr_arbiter #(.HOLD_MAX(0), .HOLD_W(8)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    // Count one comparison and report it when it disagrees.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // First requester at or after start, wrapping; -1 if none.
    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_holder[m] = -1;
            m_cnt[m]    = 0;
            m_ptr[m]    = 0;
            m_sel[m]    = 0;
            m_to[m]     = 0;
        end
    endtask

    // Advance both models by one clock given the inputs seen at that edge.
    task automatic model_edge(input logic [3:0] r, input logic d);
        for (int m = 0; m < 2; m++) begin
            int w;
            m_to[m] = 0;
            if (m_holder[m] < 0) begin
                w = pick(r, m_ptr[m]);
                if (w >= 0) begin
                    m_holder[m] = w;
                    m_sel[m]    = w;
                    m_cnt[m]    = 1;
                end
            end else begin
                bit a, b, c;
                a = d;
                b = !r[m_holder[m]];
                c = (hold_max[m] != 0) && (m_cnt[m] == hold_max[m]);
                if (a || b || c) begin
                    m_ptr[m] = (m_holder[m] + 1) % 4;
                    m_to[m]  = (c && !a && !b) ? 1 : 0;
                    w = pick(r, m_ptr[m]);
                    if (w >= 0) begin
                        m_holder[m] = w;
                        m_sel[m]    = w;
                        m_cnt[m]    = 1;
                    end else begin
                        m_holder[m] = -1;
                        m_cnt[m]    = 0;
                    end
                end else begin
                    m_cnt[m]++;
                end
            end
        end
    endtask

    function automatic logic [3:0] exp_grant(input int m);
        return (m_holder[m] < 0) ? 4'b0000 : 4'(1 << m_holder[m]);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".grant4"},   32'(bus4.grant_o),   32'(exp_grant(0)));
        check({tag, ".select4"},  32'(bus4.select_o),  32'(m_sel[0]));
        check({tag, ".busy4"},    32'(bus4.busy_o),    32'(m_holder[0] >= 0));
        check({tag, ".timeout4"}, 32'(bus4.timeout_o), 32'(m_to[0]));
        check({tag, ".grant0"},   32'(bus0.grant_o),   32'(exp_grant(1)));
        check({tag, ".select0"},  32'(bus0.select_o),  32'(m_sel[1]));
        check({tag, ".busy0"},    32'(bus0.busy_o),    32'(m_holder[1] >= 0));
        check({tag, ".timeout0"}, 32'(bus0.timeout_o), 32'(m_to[1]));
    endtask

    // Apply inputs, clock once, update model, compare 1 time unit after the edge.
    task automatic cycle(input string tag, input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
        compare_all(tag);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all("reset");
        reset_n = 1'b1;
    endtask

    initial begin
        req     = 4'b1111;
        done    = 1'b0;
        reset_n = 1'b0;
        model_reset();

        // Reset held with all requests asserted: outputs stay zero.
        repeat (3) @(posedge clk);
        #1;
        compare_all("rst_hold");
        check("rst_grant_lit", 32'(bus4.grant_o), 32'h0);
        reset_n = 1'b1;

        // Single request, then done with request dropped.
        cycle("single", 4'b0100, 1'b0);
        check("single_grant_lit", 32'(bus4.grant_o), 32'h4);
        check("single_sel_lit",   32'(bus4.select_o), 32'h2);
        cycle("single_hold", 4'b0100, 1'b0);
        cycle("single_done", 4'b0000, 1'b1);
        check("idle_sel_kept", 32'(bus4.select_o), 32'h2);
        check("idle_busy_lit", 32'(bus4.busy_o), 32'h0);

        // Round-robin rotation with a done per grant.
        apply_reset();
        cycle("rot_first", 4'b1111, 1'b0);
        check("rot_g0", 32'(bus4.grant_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] want;
            want = 4'(1 << ((i + 1) % 4));
            cycle("rot", 4'b1111, 1'b1);
            check("rot_seq", 32'(bus4.grant_o), 32'(want));
        end

        // Holder drops its request.
        apply_reset();
        cycle("drop_g1", 4'b0010, 1'b0);
        cycle("drop_both", 4'b1010, 1'b0);
        cycle("drop", 4'b1000, 1'b0);
        check("drop_grant_lit", 32'(bus4.grant_o), 32'h8);
        check("drop_sel_lit",   32'(bus4.select_o), 32'h3);

        // Hold limit without done: switch with timeout.
        apply_reset();
        cycle("lim_g0", 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) cycle("lim_hold", 4'b0011, 1'b0);
        check("lim_still0", 32'(bus4.grant_o), 32'h1);
        cycle("lim_switch", 4'b0011, 1'b0);
        check("lim_grant_lit", 32'(bus4.grant_o), 32'h2);
        check("lim_to_lit",    32'(bus4.timeout_o), 32'h1);
        cycle("lim_after", 4'b0011, 1'b0);
        check("lim_to_pulse", 32'(bus4.timeout_o), 32'h0);

        // Hold limit coinciding with done: switch, no timeout.
        apply_reset();
        cycle("limd_g0", 4'b0011, 1'b0);
        for (int i = 0; i < 3; i++) cycle("limd_hold", 4'b0011, 1'b0);
        cycle("limd_switch", 4'b0011, 1'b1);
        check("limd_grant_lit", 32'(bus4.grant_o), 32'h2);
        check("limd_to_lit",    32'(bus4.timeout_o), 32'h0);

        // Single requester under the limit: periodic timeout, grant stays.
        apply_reset();
        for (int i = 0; i < 13; i++) cycle("solo", 4'b0001, 1'b0);

        // Asynchronous reset mid-grant.
        apply_reset();
        cycle("mid_g3", 4'b1000, 1'b0);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("mid_grant", 32'(bus4.grant_o),  32'h0);
        check("mid_busy",  32'(bus4.busy_o),   32'h0);
        check("mid_sel",   32'(bus4.select_o), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle("mid_restart", 4'b1001, 1'b0);
        check("mid_restart_lit", 32'(bus4.grant_o), 32'h1);

        // Randomized traffic with occasional resets.
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       d;
            if ($urandom_range(0, 99) == 0) begin
                apply_reset();
            end else begin
                r = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
                d = ($urandom_range(0, 4) == 0);
                cycle("rand", r, d);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
